// File: rtl/ins_fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory address/data and the
// IF/ID pipeline register outputs. The slave modport is the fetch unit.
interface ins_fetch_if #(
  parameter int PC_WIDTH          = 32,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic                         start;
  logic                         halt;
  logic                         stall;
  logic                         redirect;
  logic [PC_WIDTH-1:0]          redirect_target;
  logic [PC_WIDTH-1:0]          pc_address;
  logic [INSTRUCTION_WIDTH-1:0] instruction_in;
  logic [INSTRUCTION_WIDTH-1:0] if_id_instruction;
  logic [PC_WIDTH-1:0]          if_id_pc;
  logic                         if_id_valid;
  logic                         running;
  logic                         misaligned;

  modport slave (
    input  start, halt, stall, redirect, redirect_target, instruction_in,
    output pc_address, if_id_instruction, if_id_pc, if_id_valid, running, misaligned
  );

  modport master (
    output start, halt, stall, redirect, redirect_target, instruction_in,
    input  pc_address, if_id_instruction, if_id_pc, if_id_valid, running, misaligned
  );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the PC, addresses a combinational instruction
// memory and registers the returned word into the IF/ID pipeline register.
// Optional feature macro: INS_FETCH_MISALIGN_CHECK_EN -- when defined, a
// redirect to a non-word-aligned target halts the stage and sets a sticky
// misaligned flag; when undefined the target's low two bits are cleared.
module ins_fetch #(
  parameter int                           PC_WIDTH          = 32,
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]          RESET_PC          = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = INSTRUCTION_WIDTH'(32'h0000_0013)
) (
  input logic         clk,
  input logic         rst,
  ins_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                       r_state, w_state_next;
  logic [PC_WIDTH-1:0]          r_pc, w_pc_next;
  logic [INSTRUCTION_WIDTH-1:0] r_ifid_instr, w_ifid_instr_next;
  logic [PC_WIDTH-1:0]          r_ifid_pc, w_ifid_pc_next;
  logic                         r_ifid_valid, w_ifid_valid_next;
  logic [PC_WIDTH-1:0]          w_pc_plus4;
  logic [PC_WIDTH-1:0]          w_target;

  // Sequential PC increment wraps naturally at 2^PC_WIDTH.
  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
  // Word-aligned version of the redirect target.
  assign w_target   = bus.redirect_target & ~PC_WIDTH'(3);

`ifdef INS_FETCH_MISALIGN_CHECK_EN
  logic r_misaligned, w_misaligned_next;
  logic w_target_bad;
  assign w_target_bad = |bus.redirect_target[1:0];
`endif

  // State, PC, IF/ID and flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= RESET_PC;
      r_ifid_valid <= 1'b0;
`ifdef INS_FETCH_MISALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_pc    <= w_ifid_pc_next;
      r_ifid_valid <= w_ifid_valid_next;
`ifdef INS_FETCH_MISALIGN_CHECK_EN
      r_misaligned <= w_misaligned_next;
`endif
    end
  end

  // Next-state and next-register logic; in RUN: redirect > stall > halt > fetch.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_ifid_instr_next = r_ifid_instr;
    w_ifid_pc_next    = r_ifid_pc;
    w_ifid_valid_next = r_ifid_valid;
`ifdef INS_FETCH_MISALIGN_CHECK_EN
    w_misaligned_next = r_misaligned;
`endif

    case (r_state)
      S_IDLE: begin
        // Held at the reset image; the start edge itself fetches nothing.
        w_pc_next         = RESET_PC;
        w_ifid_instr_next = NOP_INSTR;
        w_ifid_pc_next    = RESET_PC;
        w_ifid_valid_next = 1'b0;
        if (bus.start) begin
          w_state_next = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.redirect) begin
`ifdef INS_FETCH_MISALIGN_CHECK_EN
          if (w_target_bad) begin
            // Refuse the jump: stop fetching, keep PC, report the fault.
            w_state_next      = S_HALT;
            w_ifid_instr_next = NOP_INSTR;
            w_ifid_valid_next = 1'b0;
            w_misaligned_next = 1'b1;
          end else begin
            w_pc_next         = w_target;
            w_ifid_instr_next = NOP_INSTR;
            w_ifid_valid_next = 1'b0;
          end
`else
          w_pc_next         = w_target;
          w_ifid_instr_next = NOP_INSTR;
          w_ifid_valid_next = 1'b0;
`endif
        end else if (bus.stall) begin
          // Hold everything; defaults already do that.
        end else if (bus.halt) begin
          w_state_next      = S_HALT;
          w_ifid_instr_next = NOP_INSTR;
          w_ifid_valid_next = 1'b0;
        end else begin
          w_ifid_instr_next = bus.instruction_in;
          w_ifid_pc_next    = r_pc;
          w_ifid_valid_next = 1'b1;
          w_pc_next         = w_pc_plus4;
        end
      end

      S_HALT: begin
        // Bubble is already in IF/ID; resume at the held PC.
        if (bus.start) begin
          w_state_next = S_RUN;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.pc_address        = r_pc;
  assign bus.if_id_instruction = r_ifid_instr;
  assign bus.if_id_pc          = r_ifid_pc;
  assign bus.if_id_valid       = r_ifid_valid;
  assign bus.running           = (r_state == S_RUN);
`ifdef INS_FETCH_MISALIGN_CHECK_EN
  assign bus.misaligned        = r_misaligned;
`else
  assign bus.misaligned        = 1'b0;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: a vector table for the main run plus
// hand-written sequences for misaligned redirect and mid-run reset.
module tb_ins_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ins_fetch_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32)) bus ();

  ins_fetch #(
    .PC_WIDTH(32),
    .INSTRUCTION_WIDTH(32),
    .RESET_PC(32'h0),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Combinational instruction memory: word at byte address a is 0x1000 + a/4.
  assign bus.instruction_in = 32'h1000 + (bus.pc_address >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        halt;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] exp_pc_address;
    logic [31:0] exp_instr;
    logic [31:0] exp_ifid_pc;
    logic        chk_ifid_pc;
    logic        exp_valid;
    logic        exp_running;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic hl, input logic sl, input logic rd,
                     input logic [31:0] tg, input logic [31:0] pa, input logic [31:0] ins,
                     input logic [31:0] ipc, input logic cpc, input logic vl, input logic rn);
    vec_t v;
    v.start = st; v.halt = hl; v.stall = sl; v.redirect = rd; v.target = tg;
    v.exp_pc_address = pa; v.exp_instr = ins; v.exp_ifid_pc = ipc;
    v.chk_ifid_pc = cpc; v.exp_valid = vl; v.exp_running = rn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic hl, input logic sl, input logic rd,
                       input logic [31:0] tg);
    bus.start = st; bus.halt = hl; bus.stall = sl; bus.redirect = rd; bus.redirect_target = tg;
  endtask

  task automatic chk_reset_image(input string tag);
    chk({tag, ".pc_address"}, bus.pc_address, 32'h0);
    chk({tag, ".instr"},      bus.if_id_instruction, NOP);
    chk({tag, ".ifid_pc"},    bus.if_id_pc, 32'h0);
    chk({tag, ".valid"},      {31'b0, bus.if_id_valid}, 32'h0);
    chk({tag, ".running"},    {31'b0, bus.running}, 32'h0);
    chk({tag, ".misaligned"}, {31'b0, bus.misaligned}, 32'h0);
  endtask

  // One clock step: inputs already applied, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%h ifid_pc=%h instr=%h valid=%b run=%b mis=%b", $time,
             bus.pc_address, bus.if_id_pc, bus.if_id_instruction,
             bus.if_id_valid, bus.running, bus.misaligned);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    //  st hl sl rd target        pc_addr       instr         ifid_pc      cpc vl rn
    add(0, 0, 0, 1, 32'h80,       32'h0,        NOP,          32'h0,       1,  0, 0); // IDLE ignores redirect
    add(1, 0, 0, 0, 32'h0,        32'h0,        NOP,          32'h0,       1,  0, 1); // start, no capture
    add(0, 0, 0, 0, 32'h0,        32'h4,        32'h1000,     32'h0,       1,  1, 1);
    add(0, 0, 0, 0, 32'h0,        32'h8,        32'h1001,     32'h4,       1,  1, 1);
    add(0, 0, 1, 0, 32'h0,        32'h8,        32'h1001,     32'h4,       1,  1, 1); // stall x3
    add(0, 0, 1, 0, 32'h0,        32'h8,        32'h1001,     32'h4,       1,  1, 1);
    add(0, 0, 1, 0, 32'h0,        32'h8,        32'h1001,     32'h4,       1,  1, 1);
    add(0, 0, 0, 0, 32'h0,        32'hC,        32'h1002,     32'h8,       1,  1, 1);
    add(0, 0, 0, 0, 32'h0,        32'h10,       32'h1003,     32'hC,       1,  1, 1);
    add(0, 1, 0, 0, 32'h0,        32'h10,       NOP,          32'h0,       0,  0, 0); // halt at 0x10
    add(0, 1, 1, 1, 32'h80,       32'h10,       NOP,          32'h0,       0,  0, 0); // HALT ignores all
    add(1, 0, 0, 0, 32'h0,        32'h10,       NOP,          32'h0,       0,  0, 1); // resume
    add(0, 0, 0, 0, 32'h0,        32'h14,       32'h1004,     32'h10,      1,  1, 1);
    add(0, 0, 1, 1, 32'h40,       32'h40,       NOP,          32'h0,       0,  0, 1); // redirect beats stall
    add(0, 0, 0, 0, 32'h0,        32'h44,       32'h1010,     32'h40,      1,  1, 1);
    add(0, 0, 0, 1, 32'hFFFF_FFFC,32'hFFFF_FFFC,NOP,          32'h0,       0,  0, 1);
    add(0, 0, 0, 0, 32'h0,        32'h0,        32'h4000_0FFF,32'hFFFF_FFFC,1, 1, 1); // wrap
    add(0, 0, 0, 0, 32'h0,        32'h4,        32'h1000,     32'h0,       1,  1, 1);
    add(1, 0, 0, 0, 32'h0,        32'h8,        32'h1001,     32'h4,       1,  1, 1); // start ignored in RUN

    #3;
    chk_reset_image("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].stall, vecs[i].redirect, vecs[i].target);
      step();
      chk($sformatf("v%0d.pc_address", i), bus.pc_address, vecs[i].exp_pc_address);
      chk($sformatf("v%0d.instr", i), bus.if_id_instruction, vecs[i].exp_instr);
      if (vecs[i].chk_ifid_pc)
        chk($sformatf("v%0d.ifid_pc", i), bus.if_id_pc, vecs[i].exp_ifid_pc);
      chk($sformatf("v%0d.valid", i), {31'b0, bus.if_id_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d.running", i), {31'b0, bus.running}, {31'b0, vecs[i].exp_running});
      chk($sformatf("v%0d.misaligned", i), {31'b0, bus.misaligned}, 32'h0);
      @(negedge clk);
    end

    // Misaligned redirect from RUN with PC = 0x8.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
    step();
`ifdef INS_FETCH_MISALIGN_CHECK_EN
    chk("mis.running",    {31'b0, bus.running}, 32'h0);
    chk("mis.pc_address", bus.pc_address, 32'h8);
    chk("mis.valid",      {31'b0, bus.if_id_valid}, 32'h0);
    chk("mis.instr",      bus.if_id_instruction, NOP);
    chk("mis.flag",       {31'b0, bus.misaligned}, 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("mis_resume.running",    {31'b0, bus.running}, 32'h1);
    chk("mis_resume.pc_address", bus.pc_address, 32'h8);
    chk("mis_resume.flag",       {31'b0, bus.misaligned}, 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("mis_fetch.ifid_pc",    bus.if_id_pc, 32'h8);
    chk("mis_fetch.instr",      bus.if_id_instruction, 32'h1002);
    chk("mis_fetch.valid",      {31'b0, bus.if_id_valid}, 32'h1);
    chk("mis_fetch.pc_address", bus.pc_address, 32'hC);
    chk("mis_fetch.flag",       {31'b0, bus.misaligned}, 32'h1);
`else
    chk("mis.running",    {31'b0, bus.running}, 32'h1);
    chk("mis.pc_address", bus.pc_address, 32'h40);
    chk("mis.valid",      {31'b0, bus.if_id_valid}, 32'h0);
    chk("mis.flag",       {31'b0, bus.misaligned}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("mis_fetch.ifid_pc",    bus.if_id_pc, 32'h40);
    chk("mis_fetch.instr",      bus.if_id_instruction, 32'h1010);
    chk("mis_fetch.valid",      {31'b0, bus.if_id_valid}, 32'h1);
    chk("mis_fetch.pc_address", bus.pc_address, 32'h44);
    chk("mis_fetch.flag",       {31'b0, bus.misaligned}, 32'h0);
`endif

    // Asynchronous reset in the middle of a running cycle.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_image("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst.running",    {31'b0, bus.running}, 32'h0);
    chk("post_rst.pc_address", bus.pc_address, 32'h0);
    chk("post_rst.valid",      {31'b0, bus.if_id_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage. It owns the program counter, drives the address of the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for the decoder. It handles stall, branch/jump redirect (with IF/ID flush), start/halt control and PC wrap-around.

## Interface

Parameters:
- PC_WIDTH, 32, width of PC and memory address
- INSTRUCTION_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value after reset and in IDLE
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) loaded on flush/halt

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  IDLE/HALT → RUN
- halt  in  1  RUN → HALT request
- stall  in  1  freeze PC and IF/ID (from hazard unit)
- redirect  in  1  taken branch/jump
- redirect_target  in  PC_WIDTH  new PC on redirect
- pc_address  out  PC_WIDTH  to instruction memory address
- instruction_in  in  INSTRUCTION_WIDTH  from instruction memory, valid same cycle
- if_id_instruction  out  INSTRUCTION_WIDTH  registered instruction
- if_id_pc  out  PC_WIDTH  PC of if_id_instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- running  out  1  state == RUN
- misaligned  out  1  sticky misaligned-target flag (see Configuration)

## Operation

- States: IDLE (reset state), RUN, HALT. Encoding free.
- IDLE: PC = RESET_PC; IF/ID = {NOP_INSTR, RESET_PC, valid 0}. start=1 → RUN at next edge; no capture on that edge.
- RUN, per edge, priority highest first:
  - redirect=1: PC ← redirect_target; IF/ID ← NOP_INSTR, valid 0 (flush; overrides stall).
  - stall=1: PC, IF/ID hold.
  - halt=1: → HALT; PC holds; IF/ID ← NOP_INSTR, valid 0.
  - otherwise: IF/ID ← {instruction_in, PC, valid 1}; PC ← PC + 4.
- HALT: PC holds; IF/ID keeps bubble; stall, redirect, halt ignored; start=1 → RUN at next edge (resume at held PC).
- IDLE: stall, redirect, halt ignored.
- start ignored in RUN.
- Arithmetic: PC + 4 truncated to PC_WIDTH; 2^PC_WIDTH−4 wraps to 0 with no flag.
- pc_address = PC register directly (no combinational path from inputs).

## Timing

- Reset (async, immediate): state IDLE, PC = RESET_PC, pc_address = RESET_PC, if_id_instruction = NOP_INSTR, if_id_pc = RESET_PC, if_id_valid = 0, running = 0, misaligned = 0.
- Fetch latency: one cycle, pc_address to if_id_* output.
- After start is sampled: first valid IF/ID (word at RESET_PC) appears 2 edges later.
- Redirect: if_id_valid = 0 for exactly one cycle. The word at redirect_target is valid after the following edge.
- Stall held N cycles: outputs frozen N cycles, no fetch lost or duplicated.
- rst mid-operation: all state returns to reset values asynchronously. Release is synchronised externally.

## Configuration

- Macro: INS_FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target[1:0] != 0 is not taken.
  - State → HALT; IF/ID is flushed; PC holds.
  - misaligned ← 1, sticky until rst. start from HALT still resumes at the held PC.
- Undefined:
  - redirect_target[1:0] is forced to 0 before loading PC.
  - misaligned tied 0; no extra state.

## Test plan

- Reset, start pulse, memory holds word[i] = 0x1000+i → if_id_valid rises 2 edges after start; if_id_pc = 0,4,8…; if_id_instruction = 0x1000,0x1001,…
- stall high 3 cycles at PC=0x8 → if_id_pc stays 0x4 and pc_address stays 0x8 for 3 cycles; next captures 0x8, no gaps.
- redirect to 0x40 together with stall → PC=0x40, if_id_valid=0 for one cycle, then if_id_pc=0x40.
- PC preset via redirect to 0xFFFF_FFFC → next if_id_pc = 0xFFFF_FFFC, pc_address wraps to 0x0.
- halt in RUN at PC=0x10 → bubble, running=0, PC holds 0x10; start → resumes with if_id_pc=0x10.
- Redirect to 0x42 → with macro: HALT, misaligned=1, PC unchanged. Without macro: PC=0x40, misaligned=0. rst mid-run (both builds): all outputs return to reset values immediately.
